// File: rtl/or8_operand_loader_pkg.sv
// Shared definitions for the OR8 operand loader: FSM encodings and the default operand width.
package or8_operand_loader_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_LOAD_A = 2'd0,
    ST_LOAD_B = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  // BIT_CNT must be able to represent WIDTH-1 plus one guard bit.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/or8_operand_loader_if.sv
// Serial-in / parallel-out bundle between the stream source, the loader and the OR8 consumer.
interface or8_operand_loader_if
  import or8_operand_loader_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  localparam int CNT_W = cnt_width(WIDTH);

  logic             SDI;
  logic             SDI_VALID;
  logic             CLR;
  logic             READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             VALID;
  logic             BUSY;
  logic [CNT_W-1:0] BIT_CNT;

  modport master (
    output SDI, SDI_VALID, CLR, READY,
    input  A, B, VALID, BUSY, BIT_CNT
  );

  modport slave (
    input  SDI, SDI_VALID, CLR, READY,
    output A, B, VALID, BUSY, BIT_CNT
  );
endinterface

// File: rtl/or8_operand_loader_sipo_shift_reg.sv
// Serial-in parallel-out register; shift direction picks which end the first bit lands in.
module sipo_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             SDI,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (EN) begin
      if (MSB_FIRST) q_d = {q_q[WIDTH-2:0], SDI};
      else           q_d = {SDI, q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) q_q <= '0;
    else        q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: rtl/or8_operand_loader.sv
// Collects operand A then B from a serial stream and presents them to the OR8 stage with VALID/READY.
module or8_operand_loader
  import or8_operand_loader_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                 CLK,
  input logic                 RST_N,
  or8_operand_loader_if.slave bus
);

  localparam int               CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             shift_a, shift_b;
  logic [WIDTH-1:0] a_w, b_w;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    shift_a = 1'b0;
    shift_b = 1'b0;
    // Abort outranks both the stream and the consumer handshake.
    if (bus.CLR) begin
      state_d = ST_LOAD_A;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD_A: begin
          if (bus.SDI_VALID) begin
            shift_a = 1'b1;
            if (cnt_q == LAST) begin
              state_d = ST_LOAD_B;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_LOAD_B: begin
          if (bus.SDI_VALID) begin
            shift_b = 1'b1;
            if (cnt_q == LAST) begin
              state_d = ST_HOLD;
              cnt_d   = '0;
              valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // Stream bits arriving here are dropped, including the one in the handshake cycle.
          if (valid_q && bus.READY) begin
            state_d = ST_LOAD_A;
            cnt_d   = '0;
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_LOAD_A;
          cnt_d   = '0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_LOAD_A;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  sipo_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sipo_a (
    .CLK   (CLK),
    .RST_N (RST_N),
    .EN    (shift_a),
    .SDI   (bus.SDI),
    .Q     (a_w)
  );

  sipo_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sipo_b (
    .CLK   (CLK),
    .RST_N (RST_N),
    .EN    (shift_b),
    .SDI   (bus.SDI),
    .Q     (b_w)
  );

  assign bus.A       = a_w;
  assign bus.B       = b_w;
  assign bus.VALID   = valid_q;
  assign bus.BIT_CNT = cnt_q;
  assign bus.BUSY    = (state_q == ST_LOAD_B) ||
                       ((state_q == ST_LOAD_A) && (cnt_q != '0));

endmodule
